// File: rtl/flex_counter_proj_if.sv
// Control/status bundle for flex_counter_proj: the enable strobe going in and the done flag coming out.
interface flex_counter_proj_if;
  logic count_enable;
  logic done_flag;

  modport master (output count_enable, input done_flag);
  modport slave  (input count_enable, output done_flag);
endinterface

// File: rtl/flex_counter_proj.sv
// Enable-gated up-counter that flags done while the count sits at NUM_TO_COUNT;
// an enabled edge at the terminal value wraps to 1 so done recurs every NUM_TO_COUNT enabled edges.
module flex_counter_proj #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned NUM_TO_COUNT = 8
) (
    input logic               clk,
    input logic               rst,
    flex_counter_proj_if.slave cnt_if
);

    if ((NUM_TO_COUNT == 0) ||
        (longint'(NUM_TO_COUNT) >= (longint'(1) << NUM_CNT_BITS))) begin : g_bad_param
        $fatal(1, "flex_counter_proj: NUM_TO_COUNT out of range for NUM_CNT_BITS");
    end

    localparam logic [NUM_CNT_BITS-1:0] TERMINAL = NUM_CNT_BITS'(NUM_TO_COUNT);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (cnt_if.count_enable) begin
            count_d = (count_q == TERMINAL) ? NUM_CNT_BITS'(1)
                                            : count_q + NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decoded from the register only, so done never follows count_enable combinationally.
    assign cnt_if.done_flag = (count_q == TERMINAL);

endmodule

// File: tb/tb_flex_counter_proj.sv
// Directed bench for flex_counter_proj at NUM_CNT_BITS=6, NUM_TO_COUNT=40.
module tb_flex_counter_proj;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    flex_counter_proj_if ifc ();

    flex_counter_proj #(
        .NUM_CNT_BITS(6),
        .NUM_TO_COUNT(40)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cnt_if(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive enable away from the active edge, then sample 1 unit after it.
    task automatic step(input logic en);
        @(negedge clk);
        ifc.count_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.count_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            checks++;
            if (ifc.done_flag !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_done cycle=%0d got=%b exp=0", i, ifc.done_flag);
            end
            checks++;
            if (dut.count_q !== 6'd0) begin
                failures++;
                $display("FAIL reset_idle_count cycle=%0d got=%0d exp=0", i, dut.count_q);
            end
        end
    endtask

    task automatic test_full_count();
        for (int i = 1; i <= 39; i++) step(1'b1);
        checks++;
        if (ifc.done_flag !== 1'b0) begin
            failures++;
            $display("FAIL full_count_39_done got=%b exp=0", ifc.done_flag);
        end
        checks++;
        if (dut.count_q !== 6'd39) begin
            failures++;
            $display("FAIL full_count_39_count got=%0d exp=39", dut.count_q);
        end
        step(1'b1);
        checks++;
        if (ifc.done_flag !== 1'b1) begin
            failures++;
            $display("FAIL full_count_40_done got=%b exp=1", ifc.done_flag);
        end
        checks++;
        if (dut.count_q !== 6'd40) begin
            failures++;
            $display("FAIL full_count_40_count got=%0d exp=40", dut.count_q);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            checks++;
            if (ifc.done_flag !== 1'b1 || dut.count_q !== 6'd40) begin
                failures++;
                $display("FAIL hold cycle=%0d got done=%b count=%0d exp done=1 count=40",
                         i, ifc.done_flag, dut.count_q);
            end
        end
    endtask

    task automatic test_rollover();
        step(1'b1);
        checks++;
        if (ifc.done_flag !== 1'b0 || dut.count_q !== 6'd1) begin
            failures++;
            $display("FAIL rollover_wrap got done=%b count=%0d exp done=0 count=1",
                     ifc.done_flag, dut.count_q);
        end
        for (int i = 2; i <= 39; i++) begin
            step(1'b1);
            checks++;
            if (ifc.done_flag !== 1'b0) begin
                failures++;
                $display("FAIL rollover_mid count_exp=%0d got done=%b exp=0", i, ifc.done_flag);
            end
        end
        step(1'b1);
        checks++;
        if (ifc.done_flag !== 1'b1 || dut.count_q !== 6'd40) begin
            failures++;
            $display("FAIL rollover_done got done=%b count=%0d exp done=1 count=40",
                     ifc.done_flag, dut.count_q);
        end
    endtask

    task automatic test_gapped();
        logic exp_done;
        apply_reset();
        // Enable on even cycles only: the 40th enabled edge is cycle 78.
        for (int i = 0; i < 80; i++) begin
            step((i % 2) == 0);
            exp_done = (i >= 78);
            checks++;
            if (ifc.done_flag !== exp_done) begin
                failures++;
                $display("FAIL gapped cycle=%0d got=%b exp=%b", i, ifc.done_flag, exp_done);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 25; i++) step(1'b1);
        checks++;
        if (dut.count_q !== 6'd25) begin
            failures++;
            $display("FAIL async_pre_count got=%0d exp=25", dut.count_q);
        end
        @(negedge clk);
        ifc.count_enable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.count_q !== 6'd0 || ifc.done_flag !== 1'b0) begin
            failures++;
            $display("FAIL async_immediate got count=%0d done=%b exp count=0 done=0",
                     dut.count_q, ifc.done_flag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.count_q !== 6'd0) begin
            failures++;
            $display("FAIL async_over_enabled_edge got=%0d exp=0", dut.count_q);
        end
        @(negedge clk);
        rst = 1'b0;
        ifc.count_enable = 1'b0;
        for (int i = 0; i < 39; i++) step(1'b1);
        checks++;
        if (ifc.done_flag !== 1'b0 || dut.count_q !== 6'd39) begin
            failures++;
            $display("FAIL async_post_39 got done=%b count=%0d exp done=0 count=39",
                     ifc.done_flag, dut.count_q);
        end
        step(1'b1);
        checks++;
        if (ifc.done_flag !== 1'b1) begin
            failures++;
            $display("FAIL async_post_40 got=%b exp=1", ifc.done_flag);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        ifc.count_enable = 1'b0;
        test_reset();
        test_full_count();
        test_hold();
        test_rollover();
        test_gapped();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
